// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: FSM states, opcodes,
// ALU-decoder operation codes and the control word produced per state.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECUTE,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // pcen is not part of the word; it also depends on the zero flag.
  typedef struct packed {
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic       branch;
    logic       pcwrite;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/main_controller_outdec.sv
// Combinational state-to-control-word decoder for the multicycle controller.
module main_controller_outdec
  import mips_pkg::*;
(
  input  state_t state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.alusrcb = 2'b01;
        // Hold IR and PC while memory has not returned the instruction.
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      S_DECODE:  ctrl_o.alusrcb = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = 2'b10;
      end
      S_MEMRD:   ctrl_o.iord = 1'b1;
      S_MEMWR: begin
        ctrl_o.iord     = 1'b1;
        ctrl_o.memwrite = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.memtoreg = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_ALUWB: begin
        ctrl_o.regdst   = 1'b1;
        ctrl_o.regwrite = 1'b1;
      end
      S_ADDIWB:  ctrl_o.regwrite = 1'b1;
      S_EXECUTE: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      S_BRANCH: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_SUB;
        ctrl_o.pcsrc   = 2'b01;
        ctrl_o.branch  = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pcsrc   = 2'b10;
        ctrl_o.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/main_controller.sv
// Multicycle MIPS main controller: Moore FSM, retired-instruction counter and
// illegal-opcode pulse; control outputs come from main_controller_outdec.
module main_controller
  import mips_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [5:0]          op,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regwrite,
  output logic                iord,
  output logic                regdst,
  output logic                memtoreg,
  output logic                alusrca,
  output logic                branch,
  output logic                pcwrite,
  output logic                pcen,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic [1:0]          aluop,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  state_t              state_q, state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                illegal_q, illegal_d;
  logic                retire;
  ctrl_t               ctrl_raw, ctrl;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_d = S_FETCH;
      S_EXECUTE: state_d = S_ALUWB;
      S_ADDIEX:  state_d = S_ADDIWB;
      default:   state_d = S_FETCH;
    endcase
  end

  assign illegal_d = (state_q == S_DECODE) && !op_is_legal(op);
  // Only completing states count; an illegal op leaves from DECODE.
  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWR, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (retire) retired_q <= retired_q + RETIRE_W'(1);
    end
  end

  main_controller_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl_raw)
  );

  // FETCH decodes to nonzero controls, so reset must mask them directly.
  assign ctrl = reset_n ? ctrl_raw : '0;

  assign memwrite   = ctrl.memwrite;
  assign irwrite    = ctrl.irwrite;
  assign regwrite   = ctrl.regwrite;
  assign iord       = ctrl.iord;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign alusrca    = ctrl.alusrca;
  assign branch     = ctrl.branch;
  assign pcwrite    = ctrl.pcwrite;
  assign alusrcb    = ctrl.alusrcb;
  assign pcsrc      = ctrl.pcsrc;
  assign aluop      = ctrl.aluop;
  assign pcen       = ctrl.pcwrite | (ctrl.branch & zero);
  assign illegal_op = illegal_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_main_controller.sv
// Directed-vector bench for main_controller; a narrow retired counter exposes wrap.
module tb_main_controller;

  localparam int RW = 3;

  // Control word order: memwrite irwrite regwrite iord regdst memtoreg alusrca
  // branch pcwrite pcen alusrcb[1:0] pcsrc[1:0] aluop[1:0]
  localparam logic [15:0] C_RST    = 16'h0000;
  localparam logic [15:0] C_FETCH  = 16'h40D0;
  localparam logic [15:0] C_FSTALL = 16'h0010;
  localparam logic [15:0] C_DECODE = 16'h0030;
  localparam logic [15:0] C_MEMADR = 16'h0220;
  localparam logic [15:0] C_MEMRD  = 16'h1000;
  localparam logic [15:0] C_MEMWR  = 16'h9000;
  localparam logic [15:0] C_MEMWB  = 16'h2400;
  localparam logic [15:0] C_ALUWB  = 16'h2800;
  localparam logic [15:0] C_ADDIWB = 16'h2000;
  localparam logic [15:0] C_EXEC   = 16'h0202;
  localparam logic [15:0] C_BRT    = 16'h0345;
  localparam logic [15:0] C_BRNT   = 16'h0305;
  localparam logic [15:0] C_JUMP   = 16'h00C8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [5:0]    op;
  logic          zero;
  logic          mem_ready;
  logic          memwrite, irwrite, regwrite, iord, regdst, memtoreg;
  logic          alusrca, branch, pcwrite, pcen;
  logic [1:0]    alusrcb, pcsrc, aluop;
  logic          illegal_op;
  logic [RW-1:0] retired;
  logic [15:0]   ctrl_obs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  main_controller #(.RETIRE_W(RW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .iord       (iord),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .branch     (branch),
    .pcwrite    (pcwrite),
    .pcen       (pcen),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .aluop      (aluop),
    .illegal_op (illegal_op),
    .retired    (retired)
  );

  assign ctrl_obs = {memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca,
                     branch, pcwrite, pcen, alusrcb, pcsrc, aluop};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Check one cycle's outputs (inputs already set), then advance to next negedge.
  task automatic cyc(input string tag, input logic [15:0] ec, input logic ei, input int er);
    #1;
    chk({tag, ".ctrl"}, 32'(ctrl_obs), 32'(ec));
    chk({tag, ".ill"},  32'(illegal_op), 32'(ei));
    chk({tag, ".ret"},  32'(retired), 32'(er));
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    cyc("reset", C_RST, 1'b0, 0);
    reset_n = 1'b1;

    // lw: 5 cycles, write-back only in the last
    op = 6'b100011;
    cyc("lw.f", C_FETCH, 0, 0);  cyc("lw.d", C_DECODE, 0, 0);
    cyc("lw.a", C_MEMADR, 0, 0); cyc("lw.r", C_MEMRD, 0, 0);
    cyc("lw.wb", C_MEMWB, 0, 0);

    // sw with memory stalled 3 cycles in MEMWR
    op = 6'b101011;
    cyc("sw.f", C_FETCH, 0, 1);  cyc("sw.d", C_DECODE, 0, 1);
    cyc("sw.a", C_MEMADR, 0, 1);
    mem_ready = 1'b0;
    cyc("sw.w0", C_MEMWR, 0, 1); cyc("sw.w1", C_MEMWR, 0, 1); cyc("sw.w2", C_MEMWR, 0, 1);
    mem_ready = 1'b1;
    cyc("sw.w3", C_MEMWR, 0, 1);

    op = 6'b000000;
    cyc("r.f", C_FETCH, 0, 2);   cyc("r.d", C_DECODE, 0, 2);
    cyc("r.x", C_EXEC, 0, 2);    cyc("r.wb", C_ALUWB, 0, 2);

    op = 6'b001000;
    cyc("ai.f", C_FETCH, 0, 3);  cyc("ai.d", C_DECODE, 0, 3);
    cyc("ai.x", C_MEMADR, 0, 3); cyc("ai.wb", C_ADDIWB, 0, 3);

    op = 6'b000100; zero = 1'b1;
    cyc("bt.f", C_FETCH, 0, 4);  cyc("bt.d", C_DECODE, 0, 4);
    cyc("bt.b", C_BRT, 0, 4);
    zero = 1'b0;
    cyc("bn.f", C_FETCH, 0, 5);  cyc("bn.d", C_DECODE, 0, 5);
    cyc("bn.b", C_BRNT, 0, 5);

    // Unlisted opcode: back to FETCH, one-cycle pulse, nothing retired
    op = 6'b111111;
    cyc("il.f", C_FETCH, 0, 6);  cyc("il.d", C_DECODE, 0, 6);
    mem_ready = 1'b0;
    cyc("il.p", C_FSTALL, 1, 6); cyc("il.q", C_FSTALL, 0, 6);
    mem_ready = 1'b1;

    op = 6'b000010;
    cyc("j.f", C_FETCH, 0, 6);   cyc("j.d", C_DECODE, 0, 6);
    cyc("j.j", C_JUMP, 0, 6);

    // FETCH stalled 2 cycles; this jump retires the 8th instruction and wraps
    mem_ready = 1'b0;
    cyc("fs.0", C_FSTALL, 0, 7); cyc("fs.1", C_FSTALL, 0, 7);
    mem_ready = 1'b1;
    cyc("fs.2", C_FETCH, 0, 7);  cyc("fs.d", C_DECODE, 0, 7);
    cyc("fs.j", C_JUMP, 0, 7);
    cyc("j2.f", C_FETCH, 0, 0);  cyc("j2.d", C_DECODE, 0, 0);
    cyc("j2.j", C_JUMP, 0, 0);

    // Reset mid-MEMWR: controls drop before any clock edge
    op = 6'b101011;
    cyc("rs.f", C_FETCH, 0, 1);  cyc("rs.d", C_DECODE, 0, 1);
    cyc("rs.a", C_MEMADR, 0, 1);
    mem_ready = 1'b0;
    #1;
    chk("rs.w.ctrl", 32'(ctrl_obs), 32'(C_MEMWR));
    #1 reset_n = 1'b0;
    #1;
    chk("rs.async.ctrl", 32'(ctrl_obs), 32'(C_RST));
    chk("rs.async.ret", 32'(retired), 32'd0);
    @(negedge clk);
    mem_ready = 1'b1;
    cyc("rs.hold", C_RST, 0, 0);
    reset_n = 1'b1;

    op = 6'b000000;
    cyc("ar.f", C_FETCH, 0, 0);  cyc("ar.d", C_DECODE, 0, 0);
    cyc("ar.x", C_EXEC, 0, 0);   cyc("ar.wb", C_ALUWB, 0, 0);
    cyc("ar.end", C_FETCH, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/main_controller.md
MAIN_CONTROLLER -- requirements
Module: main_controller

Interface
REQ-001 SHALL have parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port op  input  6  opcode field from instruction register, valid from DECODE onward.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory accepts/returns this cycle.
REQ-007 SHALL have outputs, 1 bit each: memwrite, irwrite, regwrite, iord, regdst, memtoreg, alusrca, branch, pcwrite, pcen.
REQ-008 SHALL have outputs alusrcb, pcsrc and aluop, 2 bits each. aluop feeds the ALU decoder: 00 add, 01 sub, 10 use funct.
REQ-009 SHALL have outputs illegal_op (1 bit, one-cycle pulse) and retired (RETIRE_W bits, count of completed instructions).

Function
REQ-010 SHALL implement a multicycle Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
REQ-011 SHALL transition as follows: FETCH->DECODE when mem_ready=1, else hold.
REQ-012 SHALL transition out of DECODE by op: lw 100011 or sw 101011 -> MEMADR; 000000 -> EXECUTE; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other -> FETCH.
REQ-013 SHALL transition out of MEMADR by op: lw -> MEMRD; sw -> MEMWR.
REQ-014 SHALL transition MEMRD->MEMWB when mem_ready=1, else hold; MEMWR->FETCH when mem_ready=1, else hold.
REQ-015 SHALL transition EXECUTE->ALUWB and ADDIEX->ADDIWB; MEMWB, ALUWB, ADDIWB, BRANCH and JUMP SHALL go to FETCH.
REQ-016 SHALL drive every output not listed for a state to 0.
REQ-017 FETCH SHALL drive alusrcb=01, with irwrite=pcwrite=mem_ready (no PC advance while stalled).
REQ-018 DECODE SHALL drive alusrcb=11; MEMADR and ADDIEX SHALL drive alusrca=1, alusrcb=10.
REQ-019 MEMRD SHALL drive iord=1; MEMWR SHALL drive iord=1 and memwrite=1 for every cycle of the state.
REQ-020 MEMWB SHALL drive memtoreg=1, regwrite=1; ALUWB SHALL drive regdst=1, regwrite=1; ADDIWB SHALL drive regwrite=1.
REQ-021 EXECUTE SHALL drive alusrca=1, aluop=10; BRANCH SHALL drive alusrca=1, aluop=01, pcsrc=01, branch=1; JUMP SHALL drive pcsrc=10, pcwrite=1.
REQ-022 SHALL drive pcen = pcwrite | (branch & zero), combinationally.
REQ-023 SHALL assert illegal_op for exactly one cycle, in the cycle after DECODE sees an unlisted op; that instruction SHALL NOT count as retired.
REQ-024 SHALL increment retired by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP; it SHALL wrap modulo 2^RETIRE_W.
REQ-025 Latencies, with mem_ready held at 1, SHALL be: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.

Reset
REQ-026 While reset_n=0, all outputs SHALL be 0 asynchronously: state=FETCH, retired=0, illegal_op=0, and FETCH outputs masked.
REQ-027 Reset asserted mid-instruction SHALL abandon it without retiring; the first rising edge after release SHALL evaluate FETCH normally.

Structure
REQ-028 State enum, opcode constants and aluop encodings SHALL live in shared package mips_pkg, also used by the ALU decoder.
REQ-029 State-to-control-word decoding SHALL be sub-module main_controller_outdec, purely combinational; the state register, retired counter and illegal_op flop SHALL stay in main_controller.

Verification
REQ-030 lw, mem_ready=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=memtoreg=1 in cycle 5 only; retired 0->1.
REQ-031 beq, zero=1: pcen=1, aluop=01, pcsrc=01 in cycle 3. With zero=0: pcen=0 in that cycle.
REQ-032 sw, mem_ready low 3 cycles in MEMWR: memwrite=1 for 4 cycles; retired increments once.
REQ-033 FETCH, mem_ready low 2 cycles: irwrite=pcwrite=0 for 2 cycles, then 1 for exactly 1 cycle.
REQ-034 op=111111: DECODE->FETCH; illegal_op pulses once; retired unchanged.
REQ-035 reset_n low mid-MEMWR: memwrite drops without waiting for a clock edge; retired=0; after release the FSM restarts in FETCH.
